// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns / bypass engine. It accepts a 128-bit state,
// transforms COLS columns per beat in place, and returns the state on a valid/ready port.
module mix_columns_engine #(
    parameter int COLS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         N    = 4 / COLS;
    localparam logic [1:0] LAST = 2'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   mode_q, mode_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, row 0 in the MSB byte. Constant multiples come from chained xtime.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [1:0] mode);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  r;
        logic [31:0] res;
        int          j1, j2, j3;
        res = col;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            j1 = (i + 1) % 4;
            j2 = (i + 2) % 4;
            j3 = (i + 3) % 4;
            case (mode)
                2'b00:   r = x2[i] ^ x2[j1] ^ a[j1] ^ a[j2] ^ a[j3];
                2'b01:   r = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[j1] ^ x2[j1] ^ a[j1])
                           ^ (x8[j2] ^ x4[j2] ^ a[j2]) ^ (x8[j3] ^ a[j3]);
                default: r = a[i];
            endcase
            res[31-8*i -: 8] = r;
        end
        return res;
    endfunction

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = work_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = in_mode;
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Column c belongs to beat c/COLS.
                for (int c = 0; c < 4; c++) begin
                    if ((c / COLS) == 32'(cnt_q))
                        work_d[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32], mode_q);
                end
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= 128'h0;
            mode_q      <= 2'b00;
            cnt_q       <= 2'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (COLS = 1, 2, 4), directed vectors,
// back-pressure, mid-operation reset and a randomised run against a generic GF model.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] in_data = 128'h0;
    logic [1:0]   in_mode = 2'b00;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [127:0] od [3];
    int           colsv [3] = '{1, 2, 4};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_engine #(.COLS(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (ir[g]),
            .in_data  (in_data),
            .in_mode  (in_mode),
            .out_valid(ov[g]),
            .out_ready(out_ready[g]),
            .out_data (od[g]),
            .busy     (bz[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply, independent of the per-constant chains.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic [1:0] m);
        logic [7:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   r;
        logic [127:0] res;
        if (m[1]) return d;
        if (m == 2'b00) begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        else            begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        res = d;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = d[127-32*c-8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(cf[j], a[(i+j)%4]);
                res[127-32*c-8*i -: 8] = r;
            end
        end
        return res;
    endfunction

    // Accept one state on instance i, measure cycles to out_valid, then complete the handshake.
    task automatic run(input int i, input logic [127:0] d, input logic [1:0] m,
                       output logic [127:0] r, output int lat);
        int w;
        @(negedge clk);
        in_data = d; in_mode = m; in_valid[i] = 1'b1;
        w = 0;
        while (!ir[i] && w < 20) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_mode = 2'($urandom_range(0, 3));
        lat = 0;
        while (!ov[i] && lat < 20) begin @(posedge clk); #1; lat++; end
        r = od[i];
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk); out_ready[i] = 1'b1;
        @(posedge clk); #1; out_ready[i] = 1'b0;
    endtask

    typedef struct {
        int           i;
        logic [127:0] d;
        logic [1:0]   m;
        logic [127:0] e;
    } vec_t;

    localparam logic [127:0] VA  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VAF = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VB  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] VBF = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    initial begin
        vec_t         tbl [8];
        logic [127:0] r, r2;
        int           lat, i;
        logic [1:0]   m;
        logic [127:0] x;

        tbl[0] = '{0, VA,  2'b00, VAF};
        tbl[1] = '{2, VAF, 2'b01, VA};
        tbl[2] = '{1, VAF, 2'b01, VA};
        tbl[3] = '{0, VB,  2'b10, VB};
        tbl[4] = '{0, VB,  2'b00, VBF};
        tbl[5] = '{1, VB,  2'b11, VB};
        tbl[6] = '{2, VB,  2'b00, VBF};
        tbl[7] = '{1, VBF, 2'b01, VB};

        for (int k = 0; k < 3; k++) begin in_valid[k] = 1'b0; out_ready[k] = 1'b0; end
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready",  128'(ir[k]), 128'h0);
            chk("rst_out_valid", 128'(ov[k]), 128'h0);
            chk("rst_busy",      128'(bz[k]), 128'h0);
            chk("rst_out_data",  od[k],       128'h0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("idle_in_ready", 128'(ir[k]), 128'h1);

        for (int t = 0; t < 8; t++) begin
            run(tbl[t].i, tbl[t].d, tbl[t].m, r, lat);
            chk($sformatf("vec%0d_data", t), r, tbl[t].e);
            chk($sformatf("vec%0d_lat", t), 128'(lat), 128'(4 / colsv[tbl[t].i]));
        end

        // Back-pressure on COLS=1: a new request waits while DONE is held.
        @(negedge clk);
        in_data = VA; in_mode = 2'b00; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_data = VBF; in_mode = 2'b01;
        lat = 0;
        while (!ov[0] && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp_lat", 128'(lat), 128'd4);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_data",  od[0],       VAF);
            chk("bp_hold_ready", 128'(ir[0]), 128'h0);
            chk("bp_hold_valid", 128'(ov[0]), 128'h1);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("bp_release_ready", 128'(ir[0]), 128'h1);
        chk("bp_release_valid", 128'(ov[0]), 128'h0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("bp_accept_busy", 128'(bz[0]), 128'h1);
        lat = 0;
        while (!ov[0] && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp_second_data", od[0], VB);
        chk("bp_second_lat", 128'(lat), 128'd4);
        @(negedge clk); out_ready[0] = 1'b1;
        @(posedge clk); #1; out_ready[0] = 1'b0;

        // Asynchronous reset at beat 2 on COLS=1.
        @(negedge clk);
        in_data = VA; in_mode = 2'b00; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk("mid_busy_before", 128'(bz[0]), 128'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(ov[0]), 128'h0);
        chk("mid_rst_busy",  128'(bz[0]), 128'h0);
        chk("mid_rst_ready", 128'(ir[0]), 128'h0);
        @(negedge clk); @(negedge clk);
        chk("mid_rst_hold_valid", 128'(ov[0]), 128'h0);
        rst = 1'b0;
        run(0, VB, 2'b00, r, lat);
        chk("post_rst_data", r, VBF);
        chk("post_rst_lat", 128'(lat), 128'd4);

        // Randomised states across all three widths.
        for (int t = 0; t < 1000; t++) begin
            i = $urandom_range(0, 2);
            x = {$urandom, $urandom, $urandom, $urandom};
            m = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(i, x, m, r, lat);
            chk("rnd_data", r, model(x, m));
            chk("rnd_lat", 128'(lat), 128'(4 / colsv[i]));
            if (m == 2'b01) begin
                run(i, r, 2'b00, r2, lat);
                chk("rnd_roundtrip", r2, x);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Handshaked, iterative MixColumns / InvMixColumns / bypass unit for the AES-256 datapath. It accepts one full 128-bit state and processes COLS columns per clock, using shift-and-reduce GF(2^8) arithmetic rather than lookup tables. It returns the transformed state through a valid/ready output port. The encrypt and decrypt round pipelines share this block; bypass mode serves the final round, which has no MixColumns.

## Interface
- COLS, default 1 — columns processed per beat; legal values 1, 2, 4; N = 4/COLS beats per state
- clk  input  1  — rising-edge clock
- rst  input  1  — asynchronous, active-high reset
- in_valid  input  1  — in_data / in_mode valid
- in_ready  output  1  — block can accept a state
- in_data  input  128  — input state; column c = in_data[127-32c -: 32], row 0 in the MSB byte of each column
- in_mode  input  2  — 00 forward MixColumns, 01 inverse, 10 and 11 bypass
- out_valid  output  1  — out_data holds a completed state
- out_ready  input  1  — consumer accepts out_data
- out_data  output  128  — result, same column/byte layout as in_data
- busy  output  1  — high in BUSY or DONE

## Operation
- FSM with three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - on in_valid & in_ready: capture in_data into the working register, latch in_mode, clear beat counter, go to BUSY.
- BUSY:
  - in_ready = 0.
  - each cycle, transform columns k·COLS … k·COLS+COLS-1 in place, where k = beat counter.
  - counter width is 2 bits, saturating at N-1.
  - after beat N-1, go to DONE.
- DONE:
  - out_valid = 1; out_data = working register, held stable.
  - on out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- Forward mode, per column bytes a0..a3 (a0 = MSB):
  - r_i = 2·a_i ⊕ 3·a_(i+1) ⊕ a_(i+2) ⊕ a_(i+3), indices mod 4.
- Inverse mode:
  - r_i = e·a_i ⊕ b·a_(i+1) ⊕ d·a_(i+2) ⊕ 9·a_(i+3).
- Bypass mode: column unchanged; the block still takes N beats, so latency is mode-independent.
- GF arithmetic:
  - xtime(x) = {x[6:0],1'b0} ⊕ (x[7] ? 8'h1b : 8'h00).
  - 9 = x8⊕x, b = x8⊕x2⊕x, d = x8⊕x4⊕x, e = x8⊕x4⊕x2, with x2/x4/x8 built from chained xtime.
  - all intermediates are 8 bits.
- in_mode and in_data are sampled only at accept; changes while BUSY or DONE are ignored.
- in_valid while not IDLE has no effect; the source holds in_valid and in_data.
- out_ready while not DONE is ignored.

## Timing
- Reset (asynchronous assert), values while rst is high:
  - state IDLE; in_ready = 0 (in_ready = IDLE & ~rst).
  - out_valid = 0; busy = 0; out_data = 128'h0; beat counter 0; latched mode 00.
- First accept is possible on the first rising edge after rst deasserts.
- Latency: with accept at edge E0, out_valid rises after edge E0+N.
  - COLS=1: 4 cycles; COLS=2: 2 cycles; COLS=4: 1 cycle.
- Throughput, with out_ready held high: one state per N+2 cycles (accept, N beats, DONE handshake, IDLE).
- out_valid is registered; in_ready is combinational from state and rst only.
- Back-pressure: DONE persists indefinitely while out_ready = 0, with out_data unchanged.
- Reset mid-operation, in BUSY or DONE:
  - immediate return to IDLE, out_valid = 0 within the same cycle, partial result discarded.
  - no output handshake occurs for the aborted state.
- Reset coincident with the accepting edge: reset wins; nothing is captured.

## Test plan
- Forward, COLS=1:
  - stimulus: in_data = db135345_f20a225c_01010101_c6c6c6c6, mode 00.
  - required: out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid exactly 4 cycles after accept.
- Inverse, COLS=4:
  - stimulus: in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode 01.
  - required: out_data = db135345_f20a225c_01010101_c6c6c6c6; latency 1.
  - repeat with COLS=2: same data, latency 2.
- Bypass and second vector:
  - stimulus: mode 10 with in_data = d4d4d4d5_2d26314c_00000000_ffffffff.
  - required: identical out_data after N cycles.
  - then mode 00 on the same data: required d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Back-pressure:
  - stimulus: hold out_ready = 0 for 10 cycles in DONE while in_valid = 1 with new data and mode.
  - required: out_data stable, in_ready = 0, no second capture; after out_ready, in_ready = 1 on the next cycle and the pending state is accepted.
- Reset mid-BUSY, COLS=1:
  - stimulus: assert rst asynchronously at beat 2.
  - required: out_valid = 0 and busy = 0 immediately, in_ready = 0 while rst is high; a fresh vector after release produces the correct result with normal latency.
- Randomised:
  - stimulus: 1000 states with random data, mode and COLS, with random in_valid/out_ready gaps.
  - required: forward(inverse(x)) = x, and every result matches a reference GF model.
